// File: rtl/regfile_burst_port_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_burst_port_if                                                    |
// | Command, stream and register-file port bundle for regfile_burst_port.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface regfile_burst_port_if #(
    parameter int N = 64
) ();
    // command channel
    logic         cmd_valid;
    logic         cmd_ready;
    logic         cmd_op;
    logic [4:0]   cmd_base;
    logic [4:0]   cmd_count;
    // load stream
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    // dump stream
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    // register file write port and A read port
    logic [4:0]   DA;
    logic [N-1:0] D;
    logic         W;
    logic [4:0]   SA;
    logic [N-1:0] A;
    // status
    logic         busy;
    logic         done;

    // the burst port itself
    modport slave (
        input  cmd_valid, cmd_op, cmd_base, cmd_count,
        input  in_valid, in_data,
        input  out_ready,
        input  A,
        output cmd_ready, in_ready,
        output out_valid, out_data,
        output DA, D, W, SA,
        output busy, done
    );

    // the surrounding logic: command source, streams and register file
    modport master (
        output cmd_valid, cmd_op, cmd_base, cmd_count,
        output in_valid, in_data,
        output out_ready,
        output A,
        input  cmd_ready, in_ready,
        input  out_valid, out_data,
        input  DA, D, W, SA,
        input  busy, done
    );
endinterface
`default_nettype wire

// File: rtl/regfile_burst_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_burst_port                                                       |
// | Burst load/dump master for the 32x64 register file write and A ports.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module regfile_burst_port #(
    parameter int N = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    regfile_burst_port_if.slave  bus
);

    localparam logic [4:0] c_ADDR_STEP = 5'd1;
    localparam logic [4:0] c_ZERO_ADDR = 5'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DUMP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [4:0]   r_addr;
    logic [4:0]   r_remaining;
    logic         r_last_issued;
    logic         r_out_valid;
    logic [N-1:0] r_out_data;
    logic         r_busy;
    logic         r_done;

    logic w_drain;
    logic w_issue;

    // The output register refills while empty or while being drained,
    // until the final beat has been issued into it.
    assign w_drain = r_out_valid & bus.out_ready;
    assign w_issue = (r_state == ST_DUMP) & ~r_last_issued
                     & (~r_out_valid | bus.out_ready);

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= c_ZERO_ADDR;
            r_remaining   <= c_ZERO_ADDR;
            r_last_issued <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.cmd_valid) begin
                        r_addr        <= bus.cmd_base;
                        r_remaining   <= bus.cmd_count;
                        r_last_issued <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= bus.cmd_op ? ST_DUMP : ST_LOAD;
                    end
                end

                ST_LOAD: begin
                    if (bus.in_valid) begin
                        r_addr <= r_addr + c_ADDR_STEP;
                        if (r_remaining == c_ZERO_ADDR) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - c_ADDR_STEP;
                        end
                    end
                end

                ST_DUMP: begin
                    if (w_issue) begin
                        r_out_data  <= bus.A;
                        r_out_valid <= 1'b1;
                        r_addr      <= r_addr + c_ADDR_STEP;
                        if (r_remaining == c_ZERO_ADDR) begin
                            r_last_issued <= 1'b1;
                        end else begin
                            r_remaining <= r_remaining - c_ADDR_STEP;
                        end
                    end else if (w_drain) begin
                        r_out_valid <= 1'b0;
                    end
                    // Finish on the handshake of the last beat in the register.
                    if (w_drain && r_last_issued) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Handshake readiness and write enable are gated by reset so nothing is
    // accepted or written while reset is held low.
    assign bus.cmd_ready = reset & (r_state == ST_IDLE);
    assign bus.in_ready  = reset & (r_state == ST_LOAD);
    assign bus.W         = reset & (r_state == ST_LOAD) & bus.in_valid;
    assign bus.DA        = (r_state == ST_LOAD) ? r_addr : c_ZERO_ADDR;
    assign bus.D         = (r_state == ST_LOAD) ? bus.in_data : '0;
    assign bus.SA        = (r_state == ST_DUMP) ? r_addr : c_ZERO_ADDR;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_regfile_burst_port.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_burst_port                                                    |
// | Directed self-checking bench with a transaction-level reference model.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_regfile_burst_port;

    localparam int N = 64;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    regfile_burst_port_if #(.N(N)) bus ();

    regfile_burst_port #(.N(N)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] seed(input logic [4:0] a);
        seed = 64'hC0DE_0000_0000_0000 | {59'd0, a};
    endfunction

    // Register file environment: R31 discards writes and reads as zero.
    logic [N-1:0] rf [32];
    logic [31:0]  written = '0;
    always @(posedge clock) begin
        if (bus.W && bus.DA != 5'd31) begin
            rf[bus.DA]      <= bus.D;
            written[bus.DA] <= 1'b1;
        end
    end
    assign bus.A = (bus.SA == 5'd31) ? '0 : (written[bus.SA] ? rf[bus.SA] : seed(bus.SA));

    // Reference model state and scoreboards.
    logic [63:0] ref_mem [32];
    logic [4:0]  exp_wa [$];
    logic [63:0] exp_wd [$];
    logic [63:0] exp_rd [$];
    logic [4:0]  wr_log [$];
    logic [63:0] rd_log [$];
    logic [63:0] words  [$];
    logic        load_active = 1'b0;

    logic        prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [4:0]  cmp_wa;
    logic [63:0] cmp_wd;
    logic [63:0] cmp_rd;

    always @(negedge clock) begin
        if (reset) begin
            if (bus.W) begin
                check("write_has_in_valid", bus.in_valid, 1);
                if (exp_wa.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    cmp_wa = exp_wa.pop_front();
                    cmp_wd = exp_wd.pop_front();
                    check("write_addr", bus.DA, cmp_wa);
                    check("write_data", bus.D, cmp_wd);
                    wr_log.push_back(bus.DA);
                end
            end
            if (load_active && !bus.in_valid) check("no_write_on_gap", bus.W, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_rd.size() == 0) begin
                    check("unexpected_dump_beat", 1, 0);
                end else begin
                    cmp_rd = exp_rd.pop_front();
                    check("dump_data", bus.out_data, cmp_rd);
                    rd_log.push_back(bus.out_data);
                end
            end
            if (prev_stall) begin
                check("stall_hold_valid", bus.out_valid, 1);
                check("stall_hold_data", bus.out_data, prev_data);
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end else begin
            check("reset_cmd_ready", bus.cmd_ready, 0);
            check("reset_in_ready", bus.in_ready, 0);
            check("reset_W", bus.W, 0);
            prev_stall = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offers a command while idle; returns in the cycle after the accept edge.
    task automatic send_cmd(input logic op, input logic [4:0] base, input logic [4:0] cnt);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_base  = base;
        bus.cmd_count = cnt;
        @(negedge clock);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd(input string tag);
        @(negedge clock);
        check({tag, "_done_pulse"}, bus.done, 1);
        check({tag, "_busy_in_done"}, bus.busy, 1);
        check({tag, "_no_ready_in_done"}, bus.cmd_ready, 0);
        tick();
        @(negedge clock);
        check({tag, "_done_clear"}, bus.done, 0);
        check({tag, "_ready_again"}, bus.cmd_ready, 1);
        check({tag, "_idle_not_busy"}, bus.busy, 0);
        tick();
    endtask

    task automatic run_load(input logic [4:0] base, input logic [4:0] cnt, input bit gaps, input bit poke);
        logic [4:0] a;
        int beats = 0;
        int cyc = 0;
        logic v;
        for (int i = 0; i <= int'(cnt); i++) begin
            a = base + 5'(i);
            exp_wa.push_back(a);
            exp_wd.push_back(words[i]);
            ref_mem[a] = (a == 5'd31) ? 64'd0 : words[i];
        end
        wr_log.delete();
        send_cmd(1'b0, base, cnt);
        load_active = 1'b1;
        if (poke) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 1'b1;
        end
        while (beats <= int'(cnt) && cyc < 200) begin
            v = gaps ? cyc[0] : 1'b1;
            bus.in_valid = v;
            bus.in_data  = v ? words[beats] : 64'hDEAD_BEEF_DEAD_BEEF;
            @(negedge clock);
            check("load_busy", bus.busy, 1);
            check("load_in_ready", bus.in_ready, 1);
            if (poke) check("cmd_ignored_in_load", bus.cmd_ready, 0);
            tick();
            if (v) beats++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.cmd_valid = 1'b0;
        load_active   = 1'b0;
        check("load_beats", beats, int'(cnt) + 1);
        finish_cmd("load");
        check("load_write_count", wr_log.size(), int'(cnt) + 1);
        check("load_queue_drained", exp_wa.size(), 0);
    endtask

    task automatic run_dump(input logic [4:0] base, input logic [4:0] cnt,
                            input logic [3:0] pat, input int patlen, input bit full);
        int hs = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i <= int'(cnt); i++) exp_rd.push_back(ref_mem[base + 5'(i)]);
        rd_log.delete();
        send_cmd(1'b1, base, cnt);
        while (hs <= int'(cnt) && cyc < 400) begin
            bus.out_ready = pat[cyc % patlen];
            @(negedge clock);
            check("dump_busy", bus.busy, 1);
            if (cyc == 0) check("dump_first_cycle_empty", bus.out_valid, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (first < 0) first = cyc;
                last = cyc;
                hs++;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b0;
        check("dump_beats", hs, int'(cnt) + 1);
        if (full) begin
            check("dump_first_beat_cycle", first, 1);
            check("dump_last_beat_cycle", last, int'(cnt) + 1);
        end
        finish_cmd("dump");
        check("dump_read_count", rd_log.size(), int'(cnt) + 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 1'b0;
        bus.cmd_base  = 5'd0;
        bus.cmd_count = 5'd0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) ref_mem[i] = (i == 31) ? 64'd0 : seed(5'(i));

        // Reset
        repeat (3) tick();
        @(negedge clock);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_data", bus.out_data, 0);
        check("reset_done", bus.done, 0);
        check("reset_busy", bus.busy, 0);
        tick();
        reset = 1'b1;
        @(negedge clock);
        check("first_cmd_ready", bus.cmd_ready, 1);
        tick();

        // Basic load then dump
        words = '{64'hA, 64'hB, 64'hC};
        run_load(5'd4, 5'd2, 1'b0, 1'b0);
        check("lit_wr_da0", wr_log[0], 5'd4);
        check("lit_wr_da1", wr_log[1], 5'd5);
        check("lit_wr_da2", wr_log[2], 5'd6);
        run_dump(5'd4, 5'd2, 4'b0001, 1, 1'b1);
        check("lit_rd0", rd_log[0], 64'hA);
        check("lit_rd1", rd_log[1], 64'hB);
        check("lit_rd2", rd_log[2], 64'hC);

        // Address wrap through R31
        words = '{64'h11, 64'h22, 64'h33};
        run_load(5'd30, 5'd2, 1'b0, 1'b0);
        check("lit_wrap_da0", wr_log[0], 5'd30);
        check("lit_wrap_da1", wr_log[1], 5'd31);
        check("lit_wrap_da2", wr_log[2], 5'd0);
        run_dump(5'd30, 5'd2, 4'b0001, 1, 1'b1);
        check("lit_wrap_rd0", rd_log[0], 64'h11);
        check("lit_wrap_rd1", rd_log[1], 64'h0);
        check("lit_wrap_rd2", rd_log[2], 64'h33);

        // Gapped load with a stray command offered throughout
        words = '{64'h1001, 64'h1002, 64'h1003, 64'h1004, 64'h1005};
        run_load(5'd10, 5'd4, 1'b1, 1'b1);

        // Full 32-register dump with out_ready pattern 1,0,0,1
        run_dump(5'd0, 5'd31, 4'b1001, 4, 1'b0);
        check("lit_full_r0", rd_log[0], 64'h33);
        check("lit_full_r4", rd_log[4], 64'hA);
        check("lit_full_r12", rd_log[12], 64'h1003);
        check("lit_full_r20", rd_log[20], 64'hC0DE_0000_0000_0014);
        check("lit_full_r31", rd_log[31], 64'h0);

        // Reset in the middle of a dump after three beats
        begin
            int hs = 0;
            int cyc = 0;
            for (int i = 0; i < 32; i++) exp_rd.push_back(ref_mem[5'(i)]);
            send_cmd(1'b1, 5'd0, 5'd31);
            bus.out_ready = 1'b1;
            while (hs < 3 && cyc < 50) begin
                @(negedge clock);
                if (bus.out_valid && bus.out_ready) hs++;
                tick();
                cyc++;
            end
            check("abort_beats_before_reset", hs, 3);
            reset = 1'b0;
            tick();
            exp_rd.delete();
            @(negedge clock);
            check("abort_out_valid", bus.out_valid, 0);
            check("abort_no_done", bus.done, 0);
            check("abort_busy", bus.busy, 0);
            tick();
            @(negedge clock);
            check("abort_no_done_2", bus.done, 0);
            tick();
            reset = 1'b1;
            bus.out_ready = 1'b0;
            @(negedge clock);
            check("abort_ready_after_release", bus.cmd_ready, 1);
            check("abort_no_done_3", bus.done, 0);
            tick();
        end

        // Committed writes survive the reset
        run_dump(5'd4, 5'd0, 4'b0001, 1, 1'b1);
        check("lit_after_reset_r4", rd_log[0], 64'hA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: simulation time limit reached (t=%0t)", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_burst_port.md
# regfile_burst_port

Burst access master for the 32x64 register file: it drives the file's write port (DA, D, W) and A read port (SA, A) on behalf of a simple command interface. A load command streams 64-bit words from a valid/ready input into consecutive registers. A dump command streams consecutive registers out on a valid/ready output. It sits between debug/boot logic and the datapath register file, and is the initiating end of that file's port protocol.

## Interface

- N, 64, data width (matches register file word)
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block idle, command accepted on cmd_valid & cmd_ready
- cmd_op  in  1  0 = load, 1 = dump
- cmd_base  in  5  first register address
- cmd_count  in  5  beats minus one (1..32 beats)
- in_valid  in  1  load word offered
- in_ready  out  1  load word accepted
- in_data  in  N  load word
- out_valid  out  1  dump word available
- out_ready  in  1  dump word consumed
- out_data  out  N  dump word
- DA  out  5  register file write address
- D  out  N  register file write data
- W  out  1  register file write enable
- SA  out  5  register file A-select
- A  in  N  register file A bus (combinational read)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse at command completion

## Operation

- States: IDLE, LOAD, DUMP, DONE.
- IDLE: cmd_ready=1, busy=0. On cmd_valid, latch addr=cmd_base and remaining=cmd_count, then go to LOAD (op 0) or DUMP (op 1). cmd_valid outside IDLE is ignored (cmd_ready=0).
- LOAD: in_ready=1. Combinationally W=in_valid, DA=addr, D=in_data. The register file captures on the same rising edge. Per accepted beat: addr=addr+1 mod 32. If remaining=0, go to DONE; otherwise remaining-1.
- DUMP: SA=addr. out_data/out_valid form a one-entry output register.
  - The register loads A when it is empty, or when it is being drained (out_valid & out_ready), and beats remain unissued. Each load increments addr mod 32.
  - After the last beat is issued, no further loads occur.
  - Go to DONE on the handshake of the last beat.
  - Full throughput with out_ready held at 1: one beat per cycle.
- DONE: one cycle; done=1, busy=1. Next state is IDLE.
- Address wrap: 31 -> 0, no skipping. Loads to R31 are issued normally and discarded by the file. Dumps of R31 return 0.
- W=0 in every state except LOAD. DA/D/SA are don't-care when unused but are driven to 0 in IDLE.
- No read/write overlap: exactly one command active at a time.

## Timing

- Reset (reset=0 at a clock edge): state=IDLE, out_valid=0, out_data=0, done=0, busy=0, remaining=0, addr=0.
  - While reset is low, cmd_ready=0, in_ready=0, W=0. First cmd_ready=1 is the cycle after reset rises.
- Reset mid-command: abort immediately with no done pulse. Writes already committed remain; the partial dump word is dropped.
- Command accept edge T: busy=1 from T+1.
  - Load: first write can occur at edge T+1.
  - Dump: first out_valid=1 at T+2. The SA=base read is captured at edge T+1.
- Load of k beats with in_valid held high: writes at edges T+1..T+k. done=1 in cycle T+k+1, cmd_ready=1 in cycle T+k+2.
- Dump of k beats with out_ready held high: out_valid cycles T+2..T+k+1. done in T+k+2.
- out_data is stable while out_valid=1 and out_ready=0.
- in_valid gaps and out_ready stalls stretch the command with no lost or duplicated beats.

## Test plan

- Reset, then load base=4, count=2, words 0xA, 0xB, 0xC -> W pulses with DA=4,5,6; dump base=4, count=2 -> out_data 0xA, 0xB, 0xC, then done pulse.
- Wrap: load base=30, count=2, words 0x11, 0x22, 0x33 -> DA=30,31,0; dump same range -> 0x11, 0x0, 0x33.
- Dump 32 beats with out_ready toggling 1,0,0,1 -> every register emitted once, in order, with out_data held during stalls.
- Load with in_valid low on alternate cycles -> exactly count+1 writes, no W while in_valid=0.
- cmd_valid asserted during LOAD -> ignored (cmd_ready=0), no state change.
- reset=0 mid-dump after 3 beats -> out_valid=0 next cycle, no done pulse, cmd_ready=1 one cycle after reset release.
